multicycle_seq: RTL and testbench

//  Multi-cycle instruction sequencer for the CPU datapath. Steps each instruction through

---
 rtl/multicycle_seq_if.sv | 37 +++
 rtl/multicycle_seq.sv | 170 +++++++++++++++++
 tb/tb_multicycle_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_if.sv
// Bundle of sequencer control inputs and datapath strobes between the
// multi-cycle sequencer (slave side) and its environment (master side).
interface multicycle_seq_if #(
   parameter int OPW = 6
) ();
   logic           run;
   logic [OPW-1:0] instr_op;
   logic           alu_zero;
   logic           mem_ack;
   logic           mem_req;
   logic           mem_we;
   logic           mem_iord;
   logic           mem_byte;
   logic           ir_write;
   logic           pc_write;
   logic [2:0]     pc_src;
   logic [3:0]     alu_ctrl;
   logic           alu_src;
   logic           reg_dest;
   logic           reg_write;
   logic           mem_to_reg;
   logic           tlb_we;
   logic           trap;
   logic [2:0]     state;

   modport slave (
      input  run, instr_op, alu_zero, mem_ack,
      output mem_req, mem_we, mem_iord, mem_byte, ir_write, pc_write, pc_src,
             alu_ctrl, alu_src, reg_dest, reg_write, mem_to_reg, tlb_we, trap, state
   );

   modport master (
      output run, instr_op, alu_zero, mem_ack,
      input  mem_req, mem_we, mem_iord, mem_byte, ir_write, pc_write, pc_src,
             alu_ctrl, alu_src, reg_dest, reg_write, mem_to_reg, tlb_we, trap, state
   );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with per-state strobes.
// Optional feature macro ILLEGAL_TRAP_EN: illegal opcodes enter a one-cycle TRAP state.
module multicycle_seq #(
   parameter int MUL_LAT = 4,
   parameter int OPW     = 6
) (
   input logic            clk,
   input logic            rst_n,
   multicycle_seq_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

   localparam logic [OPW-1:0] OP_RMAX = OPW'(4);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
   localparam logic [OPW-1:0] OP_LDB  = OPW'(10);
   localparam logic [OPW-1:0] OP_LDW  = OPW'(11);
   localparam logic [OPW-1:0] OP_STB  = OPW'(12);
   localparam logic [OPW-1:0] OP_STW  = OPW'(13);
   localparam logic [OPW-1:0] OP_MOV  = OPW'(14);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(20);
   localparam logic [OPW-1:0] OP_JUMP = OPW'(21);
   localparam logic [OPW-1:0] OP_TLBW = OPW'(30);
   localparam logic [OPW-1:0] OP_IRET = OPW'(31);

   state_e             state_q, state_d;
   logic [OPW-1:0]     op_q, op_d;
   logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
   state_e             boundary;

   function automatic logic is_legal(input logic [OPW-1:0] op);
      return ((op <= OP_MOV) && !((op > OP_ADDI) && (op < OP_LDB))) ||
             (op == OP_BEQ) || (op == OP_JUMP) || (op == OP_TLBW) || (op == OP_IRET);
   endfunction

   function automatic logic is_load(input logic [OPW-1:0] op);
      return (op == OP_LDB) || (op == OP_LDW);
   endfunction

   function automatic logic is_store(input logic [OPW-1:0] op);
      return (op == OP_STB) || (op == OP_STW);
   endfunction

   // run only matters here and in IDLE; mid-instruction it is ignored.
   assign boundary  = bus.run ? S_FETCH : S_IDLE;
   assign bus.state = state_q;

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      mul_cnt_d      = mul_cnt_q;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_iord   = 1'b0;
      bus.mem_byte   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 3'd0;
      bus.alu_ctrl   = 4'd0;
      bus.alu_src    = 1'b0;
      bus.reg_dest   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.tlb_we     = 1'b0;
      bus.trap       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.mem_req  = 1'b1;
            bus.ir_write = bus.mem_ack;
            bus.pc_write = bus.mem_ack;
            if (bus.mem_ack) state_d = S_DECODE;
         end
         S_DECODE: begin
            op_d = bus.instr_op;
            if (is_legal(bus.instr_op)) state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
            else state_d = S_TRAP;
`else
            else state_d = boundary;
`endif
         end
         S_EXEC: begin
            if (op_q <= OP_RMAX) begin
               bus.alu_ctrl = op_q[3:0];
               // MUL holds EXEC until the counter reaches its last value.
               if ((op_q == OP_MUL) && (mul_cnt_q != CNT_LAST)) begin
                  mul_cnt_d = mul_cnt_q + 1'b1;
               end else begin
                  mul_cnt_d = '0;
                  state_d   = S_WB;
               end
            end else if (op_q == OP_ADDI) begin
               bus.alu_src = 1'b1;
               state_d     = S_WB;
            end else if (is_load(op_q) || is_store(op_q)) begin
               bus.alu_src = 1'b1;
               state_d     = S_MEM;
            end else if (op_q == OP_MOV) begin
               state_d = S_WB;
            end else begin
               if (op_q == OP_BEQ) begin
                  bus.alu_ctrl = 4'd1;
                  bus.pc_write = bus.alu_zero;
                  bus.pc_src   = 3'd1;
               end
               if (op_q == OP_JUMP) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = 3'd2;
               end
               if (op_q == OP_TLBW) bus.tlb_we = 1'b1;
               if (op_q == OP_IRET) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = 3'd3;
               end
               state_d = boundary;
            end
         end
         S_MEM: begin
            bus.mem_req  = 1'b1;
            bus.mem_iord = 1'b1;
            bus.mem_byte = (op_q == OP_LDB) || (op_q == OP_STB);
            bus.mem_we   = is_store(op_q);
            if (bus.mem_ack) state_d = is_load(op_q) ? S_WB : boundary;
         end
         S_WB: begin
            bus.reg_write  = 1'b1;
            bus.reg_dest   = (op_q <= OP_RMAX) || (op_q == OP_MOV);
            bus.mem_to_reg = is_load(op_q);
            state_d        = boundary;
         end
         S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
            bus.trap     = 1'b1;
            bus.pc_write = 1'b1;
            bus.pc_src   = 3'd4;
            state_d      = boundary;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         mul_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end
endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: table of instructions run with zero-wait memory,
// plus hand-written sequences for delayed ack, run drop and reset mid-access.
module tb_multicycle_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   exp_q[$];

   multicycle_seq_if #(.OPW(6)) bus ();

   multicycle_seq #(.MUL_LAT(4), .OPW(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic       zero;
      int lat; int alu; int ex; int rw; int rd; int m2r;
      int pcw; int psrc; int tlb; int we; int byt; int trap;
   } vec_t;

   vec_t tbl[17];

   int obs_n, obs_alu, obs_ex, obs_rw, obs_rd, obs_m2r, obs_pcw, obs_psrc;
   int obs_tlb, obs_we, obs_byt, obs_trap, obs_irw, obs_memgood;

   function automatic int outs();
      logic [18:0] o;
      o = {bus.mem_req, bus.mem_we, bus.mem_iord, bus.mem_byte, bus.ir_write,
           bus.pc_write, bus.pc_src, bus.alu_ctrl, bus.alu_src, bus.reg_dest,
           bus.reg_write, bus.mem_to_reg, bus.tlb_we, bus.trap};
      return int'(o);
   endfunction

   task automatic push(input int v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string nm, input int act);
      int e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: got %0d, no expected value queued", nm, act);
      end else begin
         e = exp_q.pop_front();
         if (act != e) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, e);
         end
      end
   endtask

   // Runs one instruction starting at a negedge in FETCH; memory acks at once
   // except for the first mem_wait cycles spent in MEM.
   task automatic run_instr(input logic [5:0] op, input logic zero, input int mem_wait);
      int waited;
      waited = 0;
      obs_n = 0; obs_alu = 0; obs_ex = 0; obs_rw = 0; obs_rd = 0; obs_m2r = 0;
      obs_pcw = 0; obs_psrc = 0; obs_tlb = 0; obs_we = 0; obs_byt = 0;
      obs_trap = 0; obs_irw = 0; obs_memgood = 0;
      bus.instr_op = op;
      bus.alu_zero = zero;
      do begin
         obs_n++;
         bus.mem_ack = 1'b1;
         if (bus.state == 3'd4 && waited < mem_wait) begin
            bus.mem_ack = 1'b0;
            waited++;
         end
         #1;
         if (bus.state == 3'd3) begin
            obs_alu = int'(bus.alu_ctrl);
            obs_ex++;
         end
         obs_rw  += int'(bus.reg_write);
         obs_rd  += int'(bus.reg_write & bus.reg_dest);
         obs_m2r += int'(bus.reg_write & bus.mem_to_reg);
         obs_pcw += int'(bus.pc_write);
         if (bus.pc_write && bus.state != 3'd1) obs_psrc = int'(bus.pc_src);
         obs_tlb  += int'(bus.tlb_we);
         obs_we   += int'(bus.mem_req & bus.mem_we);
         obs_byt  += int'(bus.mem_req & bus.mem_byte);
         obs_trap += int'(bus.trap);
         obs_irw  += int'(bus.ir_write);
         if (bus.state == 3'd4 && bus.mem_req && bus.mem_iord && bus.mem_byte && !bus.mem_we)
            obs_memgood++;
         @(posedge clk);
         @(negedge clk);
      end while (bus.state != 3'd1 && bus.state != 3'd0 && obs_n < 60);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int strobes;
      tbl[0]  = '{6'd0,  1'b0, 4, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{6'd1,  1'b0, 4, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{6'd2,  1'b0, 7, 2, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{6'd3,  1'b0, 4, 3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[4]  = '{6'd4,  1'b0, 4, 4, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[5]  = '{6'd5,  1'b0, 4, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[6]  = '{6'd10, 1'b0, 5, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0};
      tbl[7]  = '{6'd11, 1'b0, 5, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
      tbl[8]  = '{6'd12, 1'b0, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0};
      tbl[9]  = '{6'd13, 1'b0, 4, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
      tbl[10] = '{6'd14, 1'b0, 4, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[11] = '{6'd20, 1'b1, 3, 1, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0};
      tbl[12] = '{6'd20, 1'b0, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      tbl[13] = '{6'd21, 1'b0, 3, 0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0};
      tbl[14] = '{6'd30, 1'b0, 3, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0};
      tbl[15] = '{6'd31, 1'b0, 3, 0, 1, 0, 0, 0, 2, 3, 0, 0, 0, 0};
`ifdef ILLEGAL_TRAP_EN
      tbl[16] = '{6'd7,  1'b0, 3, 0, 0, 0, 0, 0, 2, 4, 0, 0, 0, 1};
`else
      tbl[16] = '{6'd7,  1'b0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
`endif

      rst_n = 1'b0;
      bus.run = 1'b0; bus.instr_op = '0; bus.alu_zero = 1'b0; bus.mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      push(0); chk("reset_state", int'(bus.state));
      push(0); chk("reset_outs", outs());
      bus.run = 1'b1; bus.mem_ack = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      push(0); chk("reset_holds_state", int'(bus.state));
      push(0); chk("reset_holds_outs", outs());
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      push(1); chk("first_fetch_state", int'(bus.state));
      push(1); chk("first_fetch_req", int'(bus.mem_req));
      push(0); chk("first_fetch_iord", int'(bus.mem_iord));

      for (int i = 0; i < 17; i++) begin
         push(tbl[i].lat); push(1); push(tbl[i].alu); push(tbl[i].ex);
         push(tbl[i].rw); push(tbl[i].rd); push(tbl[i].m2r); push(tbl[i].pcw);
         push(tbl[i].psrc); push(tbl[i].tlb); push(tbl[i].we); push(tbl[i].byt);
         push(tbl[i].trap); push(1);
         run_instr(tbl[i].op, tbl[i].zero, 0);
         chk($sformatf("op%0d_latency", tbl[i].op), obs_n);
         chk($sformatf("op%0d_end_state", tbl[i].op), int'(bus.state));
         chk($sformatf("op%0d_alu_ctrl", tbl[i].op), obs_alu);
         chk($sformatf("op%0d_exec_cycles", tbl[i].op), obs_ex);
         chk($sformatf("op%0d_reg_write", tbl[i].op), obs_rw);
         chk($sformatf("op%0d_reg_dest", tbl[i].op), obs_rd);
         chk($sformatf("op%0d_mem_to_reg", tbl[i].op), obs_m2r);
         chk($sformatf("op%0d_pc_write", tbl[i].op), obs_pcw);
         chk($sformatf("op%0d_pc_src", tbl[i].op), obs_psrc);
         chk($sformatf("op%0d_tlb_we", tbl[i].op), obs_tlb);
         chk($sformatf("op%0d_mem_we", tbl[i].op), obs_we);
         chk($sformatf("op%0d_mem_byte", tbl[i].op), obs_byt);
         chk($sformatf("op%0d_trap", tbl[i].op), obs_trap);
         chk($sformatf("op%0d_ir_write", tbl[i].op), obs_irw);
      end

      // LDB with the data access acked three cycles late.
      push(8); push(4); push(4); push(1); push(0);
      run_instr(6'd10, 1'b0, 3);
      chk("ldb_wait_latency", obs_n);
      chk("ldb_wait_mem_cycles", obs_memgood);
      chk("ldb_wait_byte_cycles", obs_byt);
      chk("ldb_wait_mem_to_reg", obs_m2r);
      chk("ldb_wait_mem_we", obs_we);

      // Dropping run mid-instruction still completes it, then parks in IDLE.
      bus.run = 1'b0;
      push(4); push(0); push(1);
      run_instr(6'd0, 1'b0, 0);
      chk("run_drop_latency", obs_n);
      chk("run_drop_end_state", int'(bus.state));
      chk("run_drop_reg_write", obs_rw);
      @(posedge clk); @(negedge clk); #1;
      push(0); chk("idle_stays", int'(bus.state));
      bus.run = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      push(1); chk("idle_to_fetch", int'(bus.state));

      // STW stalled in MEM, then reset lands during the wait.
      bus.instr_op = 6'd13; bus.mem_ack = 1'b1;
      for (int k = 0; k < 10 && bus.state != 3'd4; k++) begin
         @(posedge clk); @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      strobes = 0;
      #1;
      push(4); chk("stw_in_mem", int'(bus.state));
      push(1); chk("stw_mem_we", int'(bus.mem_we));
      repeat (2) begin
         @(posedge clk); @(negedge clk); #1;
         strobes += int'(bus.reg_write | bus.pc_write | bus.tlb_we);
      end
      push(4); chk("stw_still_waiting", int'(bus.state));
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      strobes += int'(bus.reg_write | bus.pc_write | bus.tlb_we);
      push(0); chk("mid_reset_state", int'(bus.state));
      push(0); chk("mid_reset_outs", outs());
      push(0); chk("mid_reset_strobes", strobes);
      bus.mem_ack = 1'b1;
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      push(1); chk("post_reset_fetch", int'(bus.state));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
